fp32_divider: RTL and testbench
===============================

Name: fp32_divider

Overview:
Iterative IEEE-754 single-precision divider (Result = A / B). It is the inverse-operation companion to the FP32 multiplier in the arithmetic unit and uses the same En/Ready/NaN handshake so the top-level operation select can drive either unit identically. The mantissa quotient is computed by restoring division, one bit per clock, followed by normalization and round-to-nearest-even.

Parameters:
QBITS, 26, quotient bits generated: 1 integer + 23 fraction + guard + 1 extra. Fixed; changing it is unsupported.
CANON_NAN, 32'h7FC00000, value driven on Result for any invalid operation.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
A  input  32  dividend, FP32; sampled only on an accepting edge.
B  input  32  divisor, FP32; sampled only on an accepting edge.
En  input  1  start request.
Result  output  32  quotient; holds its value until the next Ready.
Ready  output  1  one-cycle pulse; Result, NaN and DivZero are valid in that cycle.
NaN  output  1  invalid-operation flag; valid with Ready, 0 otherwise.
DivZero  output  1  finite nonzero / zero flag; valid with Ready, 0 otherwise.
Busy  output  1  high from the accepting edge until the Ready pulse, inclusive.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - Result, Ready, NaN, DivZero and Busy all = 0.
  - Internal registers are cleared; any in-flight operation is discarded with no Ready pulse.
- States: IDLE -> CHECK -> DIVIDE (26 cycles) -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on an edge with En=1, latch A and B, set Busy=1, go to CHECK. En is ignored in every other state.
- Operand fields: S = bit 31, E = bits 30:23, F = bits 22:0.
  - An operand with E=0 (zero or subnormal) is treated as signed zero (flush-to-zero).
  - Mantissa M = {1, F}.
- CHECK applies these checks in priority order; the first match jumps to DONE with the listed result:
  1. Either operand NaN (E=FF, F!=0) -> CANON_NAN, NaN=1.
  2. inf/inf or 0/0 -> CANON_NAN, NaN=1.
  3. A=inf -> {Sa^Sb, FF, 0}.
  4. B=inf -> {Sa^Sb, 0}.
  5. B=0 -> {Sa^Sb, FF, 0}, DivZero=1.
  6. A=0 -> {Sa^Sb, 0}.
  7. No match: load rem = Ma (26-bit), q = 0, exp = Ea - Eb + 127 as signed 10-bit, cnt = 0; go to DIVIDE.
- DIVIDE, one iteration per cycle:
  - If rem >= Mb: shift 1 into q and rem -= Mb; otherwise shift 0 into q.
  - Then rem <<= 1; cnt += 1.
  - Leave after cnt reaches 26, giving q[25:0] with q[25] as the integer bit.
- NORM:
  - If q[25]=1: mant = q[25:2], G = q[1], St = q[0] | (rem != 0).
  - If q[25]=0: mant = q[24:1], G = q[0], St = (rem != 0), exp -= 1.
- ROUND (nearest-even):
  - Increment mant if G & (St | mant[0]).
  - If the increment carries out of bit 23: mant = 24'h800000, exp += 1.
  - Range check on signed exp: exp >= 255 -> signed inf; exp <= 0 -> signed zero (no subnormal output).
  - Otherwise Result = {Sa^Sb, exp[7:0], mant[22:0]}.
- DONE:
  - Drive Result and flags, pulse Ready for exactly 1 cycle, clear Busy, return to IDLE.
  - A new En is accepted on the edge after the Ready cycle at the earliest.
- Latency, with En accepted at edge k:
  - Special cases: Ready high after edge k+2.
  - Normal divide: Ready high after edge k+30.
  - Latency is fixed and independent of operand values.
- NaN and DivZero are never both 1. Overflow and underflow set no flag.
- Changing A or B after acceptance must not affect the result.

Test Plan:
1. A=0x40C00000 (6.0), B=0x40000000 (2.0), En pulse at edge k -> Ready only after edge k+30, Result=0x40400000, NaN=0, DivZero=0, Busy high k+1..k+30.
2. A=0x3F800000, B=0x40400000 (1/3) -> 0x3EAAAAAB (round-up path). A=0xBF800000, B=0x3F800000 -> 0xBF800000 (exact, sign).
3. A=0x3F800000/B=0x00000000 -> 0x7F800000, DivZero=1, Ready after k+2. A=0xBF800000/B=0x00000000 -> 0xFF800000. B=0x00000001 (subnormal) gives the same results.
4. 0/0, inf/inf (0x7F800000/0xFF800000) and A=0x7FC00001 -> Result 0x7FC00000, NaN=1, Ready after k+2. 0x00000000/0x40000000 -> 0x00000000. 0x40000000/0x7F800000 -> 0x00000000.
5. Overflow: 0x7F000000/0x3E800000 -> 0x7F800000, NaN=0. Underflow: 0x00800000/0x40000000 -> 0x00000000.
6. Handshake and reset:
   - Hold En=1 continuously with changing A/B -> operands are accepted only in IDLE, one Ready per op, results match the latched operands.
   - Assert reset at k+10 of a divide -> all outputs 0 immediately and no Ready; after release, 6.0/2.0 still returns 0x40400000.

Source files
------------

// File: rtl/fp32_divider.sv
// rtl/fp32_divider.sv - iterative FP32 divider, restoring mantissa division with round-to-nearest-even
module fp32_divider #(
  parameter int          QBITS     = 26,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        En,
  output logic [31:0] Result,
  output logic        Ready,
  output logic        NaN,
  output logic        DivZero,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVIDE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [QBITS-1:0]   r_rem;
  logic [QBITS-1:0]   r_q;
  logic signed [9:0]  r_exp;
  logic [4:0]         r_cnt;
  logic [23:0]        r_mant;
  logic               r_g;
  logic               r_st;
  logic [31:0]        r_res;
  logic               r_nan;
  logic               r_dz;

  // Operand field decode of the latched operands
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic        w_sign;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_zero;
  logic        w_b_zero;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_fa     = r_a[22:0];
  assign w_fb     = r_b[22:0];
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  // Subnormals are flushed to zero, so only the exponent matters here
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);

  // One restoring-division step: trial subtract of the divisor mantissa
  logic [QBITS-1:0] w_mb;
  logic             w_rem_ge;
  logic [QBITS-1:0] w_rem_sub;
  logic [QBITS-1:0] w_rem_next;

  assign w_mb       = {2'b00, 1'b1, w_fb};
  assign w_rem_ge   = (r_rem >= w_mb);
  assign w_rem_sub  = w_rem_ge ? (r_rem - w_mb) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // Round-to-nearest-even and the exponent bump when rounding carries out
  logic              w_inc;
  logic [24:0]       w_mant_sum;
  logic [23:0]       w_mant_rnd;
  logic signed [9:0] w_exp_rnd;

  assign w_inc      = r_g & (r_st | r_mant[0]);
  assign w_mant_sum = {1'b0, r_mant} + {24'd0, w_inc};
  assign w_mant_rnd = w_mant_sum[24] ? 24'h800000 : w_mant_sum[23:0];
  assign w_exp_rnd  = r_exp + (w_mant_sum[24] ? 10'sd1 : 10'sd0);

  // Control FSM with registered outputs; reset discards any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_mant  <= '0;
      r_g     <= 1'b0;
      r_st    <= 1'b0;
      r_res   <= '0;
      r_nan   <= 1'b0;
      r_dz    <= 1'b0;
      Result  <= '0;
      Ready   <= 1'b0;
      NaN     <= 1'b0;
      DivZero <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Ready   <= 1'b0;
          NaN     <= 1'b0;
          DivZero <= 1'b0;
          if (En) begin
            r_a     <= A;
            r_b     <= B;
            Busy    <= 1'b1;
            r_state <= S_CHECK;
          end else begin
            Busy    <= 1'b0;
          end
        end

        S_CHECK: begin
          r_nan <= 1'b0;
          r_dz  <= 1'b0;
          if (w_a_nan || w_b_nan) begin
            r_res   <= CANON_NAN;
            r_nan   <= 1'b1;
            r_state <= S_DONE;
          end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            r_res   <= CANON_NAN;
            r_nan   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_a_inf) begin
            r_res   <= {w_sign, 8'hFF, 23'd0};
            r_state <= S_DONE;
          end else if (w_b_inf) begin
            r_res   <= {w_sign, 31'd0};
            r_state <= S_DONE;
          end else if (w_b_zero) begin
            r_res   <= {w_sign, 8'hFF, 23'd0};
            r_dz    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_a_zero) begin
            r_res   <= {w_sign, 31'd0};
            r_state <= S_DONE;
          end else begin
            r_rem   <= {2'b00, 1'b1, w_fa};
            r_q     <= '0;
            r_exp   <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
            r_cnt   <= 5'd0;
            r_state <= S_DIVIDE;
          end
        end

        S_DIVIDE: begin
          r_q   <= {r_q[QBITS-2:0], w_rem_ge};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(QBITS - 1)) begin
            r_state <= S_NORM;
          end
        end

        S_NORM: begin
          if (r_q[QBITS-1]) begin
            r_mant <= r_q[QBITS-1:QBITS-24];
            r_g    <= r_q[1];
            r_st   <= r_q[0] | (r_rem != '0);
          end else begin
            r_mant <= r_q[QBITS-2:QBITS-25];
            r_g    <= r_q[0];
            r_st   <= (r_rem != '0);
            r_exp  <= r_exp - 10'sd1;
          end
          r_state <= S_ROUND;
        end

        S_ROUND: begin
          r_nan <= 1'b0;
          r_dz  <= 1'b0;
          if (w_exp_rnd >= 10'sd255) begin
            r_res <= {w_sign, 8'hFF, 23'd0};
          end else if (w_exp_rnd <= 10'sd0) begin
            r_res <= {w_sign, 31'd0};
          end else begin
            r_res <= {w_sign, w_exp_rnd[7:0], w_mant_rnd[22:0]};
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          Result  <= r_res;
          NaN     <= r_nan;
          DivZero <= r_dz;
          Ready   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// tb/tb_fp32_divider.sv - randomized and directed bench for fp32_divider
module tb_fp32_divider;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        En;
  logic [31:0] Result;
  logic        Ready;
  logic        NaN;
  logic        DivZero;
  logic        Busy;

  int tests;
  int fails;

  fp32_divider dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .En      (En),
    .Result  (Result),
    .Ready   (Ready),
    .NaN     (NaN),
    .DivZero (DivZero),
    .Busy    (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        special;
    logic        nan;
    logic        dz;
    logic [31:0] res;
  } exp_t;

  // Reference: exact quotient by integer long division, rounded to nearest even
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t    r;
    logic    s;
    int      ea, eb, e, sh;
    longint  ma, mb, num, q, rm, mant, rest, half;
    logic    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    r = '0;
    r.special = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      r.nan = 1'b1;
      r.res = 32'h7FC00000;
    end else if (a_inf) begin
      r.res = {s, 8'hFF, 23'd0};
    end else if (b_inf) begin
      r.res = {s, 31'd0};
    end else if (b_zero) begin
      r.dz  = 1'b1;
      r.res = {s, 8'hFF, 23'd0};
    end else if (a_zero) begin
      r.res = {s, 31'd0};
    end else begin
      r.special = 1'b0;
      ma   = longint'({1'b1, a[22:0]});
      mb   = longint'({1'b1, b[22:0]});
      num  = ma << 30;
      q    = num / mb;
      rm   = num % mb;
      e    = ea - eb + 127;
      if (q >= (longint'(1) << 30)) sh = 7;
      else begin
        sh = 6;
        e  = e - 1;
      end
      mant = q >> sh;
      rest = q & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      up   = (rest > half) || (rest == half && rm != 0) ||
             (rest == half && rm == 0 && mant[0]);
      if (up) mant = mant + 1;
      if (mant == (longint'(1) << 24)) begin
        mant = longint'(1) << 23;
        e    = e + 1;
      end
      if (e >= 255)    r.res = {s, 8'hFF, 23'd0};
      else if (e <= 0) r.res = {s, 31'd0};
      else             r.res = {s, 8'(e), mant[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_operand();
    int k;
    k = $urandom_range(0, 15);
    case (k)
      0:       return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(0, 1) * $urandom)};
      1:       return {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
      2:       return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom) | 23'd1};
      3, 4:    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  // Drives one operation, scrambles the operand inputs after acceptance, waits for Ready
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic nan, output logic dz,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    A  = a;
    B  = b;
    En = 1'b1;
    @(posedge clk);
    #1;
    En = 1'b0;
    A  = $urandom;
    B  = $urandom;
    busy_ok = (Busy === 1'b1) && (Ready === 1'b0);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (Ready === 1'b1) begin
        lat = i;
        break;
      end
      if (Busy !== 1'b1) busy_ok = 1'b0;
    end
    if (Busy !== 1'b1) busy_ok = 1'b0;
    res = Result;
    nan = NaN;
    dz  = DivZero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    En    = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({Result, Ready, NaN, DivZero, Busy} !== 36'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h expected 0", {Result, Ready, NaN, DivZero, Busy});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({Ready, Busy} !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset ready/busy=%b expected 00", {Ready, Busy});
    end
  endtask

  task automatic test_normal();
    logic [31:0] a_v[3] = '{32'h40C00000, 32'h3F800000, 32'hBF800000};
    logic [31:0] b_v[3] = '{32'h40000000, 32'h40400000, 32'h3F800000};
    logic [31:0] r_v[3] = '{32'h40400000, 32'h3EAAAAAB, 32'hBF800000};
    logic [31:0] res;
    logic nan, dz;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(a_v[i], b_v[i], res, nan, dz, lat, busy_ok);
      tests++;
      if (res !== r_v[i] || nan !== 1'b0 || dz !== 1'b0) begin
        fails++;
        $display("FAIL normal_%0d result=%h nan=%b dz=%b expected %h 0 0", i, res, nan, dz, r_v[i]);
      end
      tests++;
      if (lat != 30 || !busy_ok) begin
        fails++;
        $display("FAIL normal_latency_%0d latency=%0d busy_ok=%0d expected 30 1", i, lat, busy_ok);
      end
      @(posedge clk);
      #1;
      tests++;
      if (Ready !== 1'b0 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL ready_pulse_%0d ready=%b busy=%b expected 0 0", i, Ready, Busy);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] a_v[10] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                             32'h00000000, 32'h7F800000, 32'h7FC00001, 32'h00000000,
                             32'h40000000, 32'h7F800000};
    logic [31:0] b_v[10] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h00000001,
                             32'h00000000, 32'hFF800000, 32'h3F800000, 32'h40000000,
                             32'h7F800000, 32'hC0000000};
    logic [31:0] r_v[10] = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 32'hFF800000,
                             32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                             32'h00000000, 32'hFF800000};
    logic        n_v[10] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic        z_v[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] res;
    logic nan, dz;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 10; i++) begin
      run_op(a_v[i], b_v[i], res, nan, dz, lat, busy_ok);
      tests++;
      if (res !== r_v[i] || nan !== n_v[i] || dz !== z_v[i] || lat != 2 || !busy_ok) begin
        fails++;
        $display("FAIL special_%0d result=%h nan=%b dz=%b lat=%0d busy_ok=%0d expected %h %b %b 2 1",
                 i, res, nan, dz, lat, busy_ok, r_v[i], n_v[i], z_v[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] res;
    logic nan, dz;
    int lat;
    bit busy_ok;
    run_op(32'h7F000000, 32'h3E800000, res, nan, dz, lat, busy_ok);
    tests++;
    if (res !== 32'h7F800000 || nan !== 1'b0 || dz !== 1'b0 || lat != 30) begin
      fails++;
      $display("FAIL overflow result=%h nan=%b dz=%b lat=%0d expected 7f800000 0 0 30", res, nan, dz, lat);
    end
    run_op(32'h00800000, 32'h40000000, res, nan, dz, lat, busy_ok);
    tests++;
    if (res !== 32'h00000000 || nan !== 1'b0 || dz !== 1'b0 || lat != 30) begin
      fails++;
      $display("FAIL underflow result=%h nan=%b dz=%b lat=%0d expected 00000000 0 0 30", res, nan, dz, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic nan, dz;
    int lat;
    bit busy_ok;
    exp_t m;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      m = model(a, b);
      run_op(a, b, res, nan, dz, lat, busy_ok);
      tests++;
      if (res !== m.res || nan !== m.nan || dz !== m.dz) begin
        fails++;
        $display("FAIL random_%0d %h/%h result=%h nan=%b dz=%b expected %h %b %b",
                 i, a, b, res, nan, dz, m.res, m.nan, m.dz);
      end
      tests++;
      if (lat != (m.special ? 2 : 30) || !busy_ok) begin
        fails++;
        $display("FAIL random_latency_%0d latency=%0d busy_ok=%0d expected %0d 1",
                 i, lat, busy_ok, m.special ? 2 : 30);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] ca, cb, ea, eb;
    int next_accept, next_ready, readies;
    exp_t m;
    next_accept = 0;
    next_ready  = 30;
    readies     = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ca = rand_normal();
      cb = rand_normal();
      A  = ca;
      B  = cb;
      En = 1'b1;
      @(posedge clk);
      if (t == next_accept) begin
        qa.push_back(ca);
        qb.push_back(cb);
      end
      #1;
      if (Ready === 1'b1) begin
        tests++;
        if (t != next_ready || qa.size() == 0) begin
          fails++;
          $display("FAIL en_held_timing ready at edge %0d expected edge %0d", t, next_ready);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          m  = model(ea, eb);
          tests++;
          if (Result !== m.res || NaN !== m.nan || DivZero !== m.dz) begin
            fails++;
            $display("FAIL en_held_result %h/%h result=%h nan=%b dz=%b expected %h %b %b",
                     ea, eb, Result, NaN, DivZero, m.res, m.nan, m.dz);
          end
          readies++;
          next_accept = t + 1;
          next_ready  = t + 31;
        end
      end
    end
    @(negedge clk);
    En = 1'b0;
    tests++;
    if (readies != 3) begin
      fails++;
      $display("FAIL en_held_count ready pulses=%0d expected 3", readies);
    end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_reset_midop();
    logic [31:0] res;
    logic nan, dz;
    int lat, stray;
    bit busy_ok;
    @(negedge clk);
    A  = 32'h40C00000;
    B  = 32'h40000000;
    En = 1'b1;
    @(posedge clk);
    #1;
    En = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({Result, Ready, NaN, DivZero, Busy} !== 36'd0) begin
      fails++;
      $display("FAIL async_reset outputs=%h expected 0", {Result, Ready, NaN, DivZero, Busy});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (Ready === 1'b1 || Busy === 1'b1) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL reset_discard stray ready/busy cycles=%0d expected 0", stray);
    end
    run_op(32'h40C00000, 32'h40000000, res, nan, dz, lat, busy_ok);
    tests++;
    if (res !== 32'h40400000 || nan !== 1'b0 || dz !== 1'b0 || lat != 30) begin
      fails++;
      $display("FAIL after_reset result=%h nan=%b dz=%b lat=%0d expected 40400000 0 0 30", res, nan, dz, lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
